// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Brief    : Job sequencer for the 2x2 systolic array: weight load, skewed
//            row streaming, column deskew into a credit-managed result FIFO.
//            Optional perf counters when SYS_CTRL_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 8,
    parameter int RES_DEPTH = 4,
    parameter int DRAIN_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_rows_i,
    input  logic [DATA_W-1:0] w11_i,
    input  logic [DATA_W-1:0] w12_i,
    input  logic [DATA_W-1:0] w21_i,
    input  logic [DATA_W-1:0] w22_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_x0_i,
    input  logic [DATA_W-1:0] in_x1_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_y0_o,
    output logic [DATA_W-1:0] res_y1_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_timeout_o,
    output logic              sys_start_o,
    output logic              sys_accept_w_in_o,
    output logic              sys_switch_in_o,
    output logic [DATA_W-1:0] sys_data_in_11_o,
    output logic [DATA_W-1:0] sys_data_in_12_o,
    output logic [DATA_W-1:0] sys_weight_in_11_o,
    output logic [DATA_W-1:0] sys_weight_in_12_o,
    input  logic [DATA_W-1:0] sys_data_out_21_i,
    input  logic [DATA_W-1:0] sys_data_out_22_i,
    input  logic              sys_valid_out_21_i,
    input  logic              sys_valid_out_22_i
`ifdef SYS_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int DRN_W = $clog2(DRAIN_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W0 = 3'd1,
        S_LOAD_W1 = 3'd2,
        S_SWITCH  = 3'd3,
        S_STREAM  = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    num_rows_q, rows_q, pushed_q;
    logic [DATA_W-1:0]   w11_q, w12_q, w21_q, w22_q;
    logic [DRN_W-1:0]    drain_q;
    logic [OCC_W-1:0]    inflight_q, count_q;
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [DATA_W-1:0]   x1_q, hold_q;
    logic                err_q;
    logic [2*DATA_W-1:0] mem_q [RES_DEPTH];

    logic [OCC_W:0]      w_occ;
    logic                w_accept, w_start_acc, w_push, w_pop;
    logic                w_last_row, w_drain_done, w_timeout;
    logic [2*DATA_W-1:0] w_head;

    // Rows in the array count against FIFO space so a result always has a slot.
    assign w_occ        = {1'b0, count_q} + {1'b0, inflight_q};
    assign in_ready_o   = (state_q == S_STREAM) && (w_occ < (OCC_W+1)'(RES_DEPTH));
    assign w_accept     = in_valid_i && in_ready_o;
    assign w_start_acc  = (state_q == S_IDLE) && start_i;
    assign w_push       = sys_valid_out_22_i && (count_q != OCC_W'(RES_DEPTH))
                          && ((state_q == S_STREAM) || (state_q == S_DRAIN));
    assign w_pop        = res_valid_o && res_ready_i;
    assign w_last_row   = (rows_q + CNT_W'(1)) == num_rows_q;
    assign w_drain_done = pushed_q == num_rows_q;
    assign w_timeout    = drain_q == DRN_W'(DRAIN_MAX - 1);

    assign busy_o           = state_q != S_IDLE;
    assign done_o           = state_q == S_DONE;
    assign err_timeout_o    = err_q;
    assign sys_start_o      = w_accept;
    assign sys_data_in_11_o = w_accept ? in_x0_i : '0;
    assign sys_data_in_12_o = x1_q;

    assign w_head      = mem_q[rptr_q];
    assign res_valid_o = count_q != '0;
    assign res_y0_o    = res_valid_o ? w_head[2*DATA_W-1:DATA_W] : '0;
    assign res_y1_o    = res_valid_o ? w_head[DATA_W-1:0]        : '0;

    always_comb begin
        state_d            = state_q;
        sys_accept_w_in_o  = 1'b0;
        sys_switch_in_o    = 1'b0;
        sys_weight_in_11_o = '0;
        sys_weight_in_12_o = '0;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_LOAD_W0;
            S_LOAD_W0: begin
                // Bottom row goes in first so it has shifted down by the second load.
                sys_accept_w_in_o  = 1'b1;
                sys_weight_in_11_o = w21_q;
                sys_weight_in_12_o = w22_q;
                state_d            = S_LOAD_W1;
            end
            S_LOAD_W1: begin
                sys_accept_w_in_o  = 1'b1;
                sys_weight_in_11_o = w11_q;
                sys_weight_in_12_o = w12_q;
                state_d            = S_SWITCH;
            end
            S_SWITCH: begin
                sys_switch_in_o = 1'b1;
                state_d         = (num_rows_q == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM:  if (w_accept && w_last_row) state_d = S_DRAIN;
            S_DRAIN:   if (w_drain_done || w_timeout) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_rows_q <= '0;
            rows_q     <= '0;
            pushed_q   <= '0;
            w11_q      <= '0;
            w12_q      <= '0;
            w21_q      <= '0;
            w22_q      <= '0;
            drain_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            x1_q       <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_start_acc) begin
                num_rows_q <= num_rows_i;
                w11_q      <= w11_i;
                w12_q      <= w12_i;
                w21_q      <= w21_i;
                w22_q      <= w22_i;
                rows_q     <= '0;
                pushed_q   <= '0;
                inflight_q <= '0;
                err_q      <= 1'b0;
            end else begin
                if (w_accept) rows_q <= rows_q + CNT_W'(1);
                if (w_push) pushed_q <= pushed_q + CNT_W'(1);
                if (w_accept && !w_push)
                    inflight_q <= inflight_q + OCC_W'(1);
                else if (!w_accept && w_push && (inflight_q != '0))
                    inflight_q <= inflight_q - OCC_W'(1);
                if ((state_q == S_DRAIN) && !w_drain_done && w_timeout)
                    err_q <= 1'b1;
            end
            drain_q <= (state_q == S_DRAIN) ? drain_q + DRN_W'(1) : '0;
            x1_q    <= w_accept ? in_x1_i : '0;
            if (sys_valid_out_21_i) hold_q <= sys_data_out_21_i;
            if (w_push) wptr_q <= wptr_q + PTR_W'(1);
            if (w_pop)  rptr_q <= rptr_q + PTR_W'(1);
            if (w_push && !w_pop)
                count_q <= count_q + OCC_W'(1);
            else if (!w_push && w_pop)
                count_q <= count_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= {hold_q, sys_data_out_22_i};
    end

`ifdef SYS_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_o <= '0;
            perf_stall_o  <= '0;
        end else if (w_start_acc) begin
            perf_cycles_o <= 32'd1;
            perf_stall_o  <= '0;
        end else begin
            if (busy_o && (perf_cycles_o != '1))
                perf_cycles_o <= perf_cycles_o + 32'd1;
            if ((state_q == S_STREAM) && in_valid_i && !in_ready_o && (perf_stall_o != '1))
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Brief    : Scoreboard bench for systolic_ctrl with a behavioural 2x2 array stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, in_valid_i, res_ready_i;
    logic [7:0]  num_rows_i;
    logic [15:0] w11_i, w12_i, w21_i, w22_i, in_x0_i, in_x1_i;
    logic        in_ready_o, res_valid_o, busy_o, done_o, err_timeout_o;
    logic [15:0] res_y0_o, res_y1_o;
    logic        sys_start_o, sys_accept_w_in_o, sys_switch_in_o;
    logic [15:0] sys_data_in_11_o, sys_data_in_12_o, sys_weight_in_11_o, sys_weight_in_12_o;
    logic [15:0] sys_data_out_21, sys_data_out_22;
    logic        sys_valid_out_21, sys_valid_out_22;
`ifdef SYS_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_accept = 0;
    int n_done   = 0;
    int cyc_cnt  = 0;
    logic [31:0] exp_q[$];
    logic        kill22 = 1'b0;

    always #5 clk = ~clk;

    systolic_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_rows_i(num_rows_i),
        .w11_i(w11_i), .w12_i(w12_i), .w21_i(w21_i), .w22_i(w22_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_x0_i(in_x0_i), .in_x1_i(in_x1_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_y0_o(res_y0_o), .res_y1_o(res_y1_o),
        .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
        .sys_start_o(sys_start_o), .sys_accept_w_in_o(sys_accept_w_in_o),
        .sys_switch_in_o(sys_switch_in_o),
        .sys_data_in_11_o(sys_data_in_11_o), .sys_data_in_12_o(sys_data_in_12_o),
        .sys_weight_in_11_o(sys_weight_in_11_o), .sys_weight_in_12_o(sys_weight_in_12_o),
`ifdef SYS_CTRL_PERF_EN
        .perf_cycles_o(perf_cycles), .perf_stall_o(perf_stall),
`endif
        .sys_data_out_21_i(sys_data_out_21), .sys_data_out_22_i(sys_data_out_22),
        .sys_valid_out_21_i(sys_valid_out_21), .sys_valid_out_22_i(sys_valid_out_22)
    );

    // Array stub: y0 = x0*w11 + x1*w21, y1 = x0*w12 + x1*w22 (Q8.8), columns skewed by a cycle.
    logic [15:0] wt0, wt1, wb0, wb1, a11, a12, a21, a22, x0s, y0p, y1p, y1pp;
    logic        st1, st2, st3;

    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        return p[23:8];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {wt0, wt1, wb0, wb1, a11, a12, a21, a22} <= '0;
            {x0s, y0p, y1p, y1pp} <= '0;
            {st1, st2, st3} <= '0;
        end else begin
            if (sys_accept_w_in_o) begin
                wt0 <= sys_weight_in_11_o; wt1 <= sys_weight_in_12_o;
                wb0 <= wt0; wb1 <= wt1;
            end
            if (sys_switch_in_o) begin
                a11 <= wt0; a12 <= wt1; a21 <= wb0; a22 <= wb1;
            end
            st1 <= sys_start_o;
            x0s <= sys_data_in_11_o;
            st2 <= st1;
            if (st1) begin
                y0p <= qmul(x0s, a11) + qmul(sys_data_in_12_o, a21);
                y1p <= qmul(x0s, a12) + qmul(sys_data_in_12_o, a22);
            end
            st3  <= st2;
            y1pp <= y1p;
        end
    end
    assign sys_valid_out_21 = st2;
    assign sys_data_out_21  = y0p;
    assign sys_valid_out_22 = st3 & ~kill22;
    assign sys_data_out_22  = y1pp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result word is consumed.
    initial forever begin
        @(negedge clk); #1;
        if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_result: got 0x%0h, expected none", {res_y0_o, res_y1_o});
            end else begin
                check("result", {res_y0_o, res_y1_o}, exp_q.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk); #2;
        if (sys_start_o) n_start++;
        if (in_valid_i && in_ready_o) n_accept++;
        if (done_o) n_done++;
        if (start_i && !busy_o) cyc_cnt = 1;
        else if (busy_o) cyc_cnt++;
    end

    task automatic do_start(input logic [7:0] n, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        start_i = 1'b1; num_rows_i = n;
        w11_i = a; w12_i = b; w21_i = c; w22_i = d;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_row(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1, input bit expect_res);
        if (expect_res) exp_q.push_back({y0, y1});
        in_valid_i = 1'b1; in_x0_i = x0; in_x1_i = x1;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (in_ready_o) begin
                @(negedge clk);
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL row_accept_timeout: got no in_ready, expected in_ready within 300 cycles");
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_o) return;
        end
        n_checks++; n_fail++;
        $display("FAIL done_timeout: got no done, expected done within 100 cycles");
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) begin
                @(negedge clk);
                check("fifo_drained", res_valid_o, 0);
                return;
            end
            @(negedge clk);
        end
        n_checks++; n_fail++;
        $display("FAIL results_missing: got %0d outstanding, expected 0", exp_q.size());
    endtask

    initial begin
        int base_s, base_d, base_a, k;
        rst = 1'b1; start_i = 0; in_valid_i = 0; res_ready_i = 0; num_rows_i = 0;
        {w11_i, w12_i, w21_i, w22_i, in_x0_i, in_x1_i} = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_flags", {done_o, err_timeout_o, in_ready_o}, 0);
        check("rst_sys_ctrl", {sys_start_o, sys_accept_w_in_o, sys_switch_in_o}, 0);
        check("rst_sys_data", {sys_data_in_11_o, sys_data_in_12_o, sys_weight_in_11_o, sys_weight_in_12_o}, 0);
        rst = 1'b0;
        res_ready_i = 1'b1;
        @(negedge clk);

        // Weight load ordering
        do_start(8'd1, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
        check("lw0_accept", {sys_accept_w_in_o, sys_switch_in_o, busy_o}, 3'b101);
        check("lw0_weights", {sys_weight_in_11_o, sys_weight_in_12_o}, 32'h0300_0400);
        @(negedge clk);
        check("lw1_accept", {sys_accept_w_in_o, sys_switch_in_o}, 2'b10);
        check("lw1_weights", {sys_weight_in_11_o, sys_weight_in_12_o}, 32'h0100_0200);
        @(negedge clk);
        check("switch", {sys_accept_w_in_o, sys_switch_in_o}, 2'b01);
        check("switch_weights", {sys_weight_in_11_o, sys_weight_in_12_o}, 0);
        @(negedge clk);
        check("switch_one_cycle", sys_switch_in_o, 0);
        send_row(16'h0100, 16'h0000, 16'h0100, 16'h0200, 1);
        wait_done();
        wait_empty();

        // Identity, 3 rows
        base_s = n_start; base_d = n_done;
        do_start(8'd3, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
        send_row(16'h0100, 16'h0200, 16'h0100, 16'h0200, 1);
        send_row(16'h0300, 16'h0400, 16'h0300, 16'h0400, 1);
        send_row(16'h0500, 16'h0600, 16'h0500, 16'h0600, 1);
        wait_done();
        wait_empty();
        check("id_start_pulses", n_start - base_s, 3);
        check("id_done_pulses", n_done - base_d, 1);
`ifdef SYS_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, cyc_cnt);
        check("perf_stall", perf_stall, 0);
`endif

        // Backpressure: 8 rows into a 4-deep FIFO
        res_ready_i = 1'b0;
        base_a = n_accept;
        do_start(8'd8, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send_row(16'(i << 8), 16'((i + 8) << 8), 16'(i << 8), 16'((i + 8) << 8), 1);
            end
            begin
                repeat (20) @(negedge clk);
                check("bp_accepts", n_accept - base_a, 4);
                check("bp_in_ready", in_ready_o, 0);
                check("bp_res_valid", res_valid_o, 1);
                res_ready_i = 1'b1;
            end
        join
        wait_done();
        wait_empty();

        // Zero-row job
        base_s = n_start;
        do_start(8'd0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
        check("z_lw0", sys_accept_w_in_o, 1);
        @(negedge clk);
        check("z_lw1", sys_accept_w_in_o, 1);
        @(negedge clk);
        check("z_switch", sys_switch_in_o, 1);
        @(negedge clk);
        check("z_done", {done_o, busy_o}, 2'b11);
        @(negedge clk);
        check("z_idle", {done_o, busy_o, res_valid_o}, 0);
        check("z_no_start", n_start - base_s, 0);

        // Drain timeout
        kill22 = 1'b1;
        do_start(8'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
        send_row(16'h0100, 16'h0200, 16'h0, 16'h0, 0);
        k = 0;
        while (!done_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("to_drain_len", k, 15);
        check("to_err_at_done", {done_o, err_timeout_o}, 2'b11);
        kill22 = 1'b0;
        @(negedge clk);
        check("to_err_sticky", {busy_o, err_timeout_o}, 2'b01);
        do_start(8'd0, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
        check("to_err_cleared", err_timeout_o, 0);
        wait_done();
        @(negedge clk);

        // Reset mid-stream
        res_ready_i = 1'b0;
        do_start(8'd3, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
        send_row(16'h0700, 16'h0800, 16'h0700, 16'h0800, 1);
        send_row(16'h0900, 16'h0A00, 16'h0900, 16'h0A00, 1);
        repeat (4) @(negedge clk);
        check("mr_res_valid_before", res_valid_o, 1);
        in_valid_i = 1'b1; in_x0_i = 16'h0B00; in_x1_i = 16'h0C00;
        rst = 1'b1;
        @(negedge clk);
        check("mr_idle", {busy_o, res_valid_o, in_ready_o, done_o}, 0);
        check("mr_sys_ctrl", {sys_start_o, sys_accept_w_in_o, sys_switch_in_o}, 0);
        check("mr_sys_data", {sys_data_in_11_o, sys_data_in_12_o, sys_weight_in_11_o, sys_weight_in_12_o}, 0);
        rst = 1'b0;
        in_valid_i = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
